// File: rtl/axistream_forwarder.sv
// Claims one packet from the forward arbiter, reads its words from the core buffer
// and streams them out as an AXI-Stream master through a small credit-limited FIFO.
module axistream_forwarder #(
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH        = 32,
  parameter int BUF_DEPTH         = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic [SN_FWD_ADDR_WIDTH-1:0]   addr,
  output logic                           rd_en,
  input  logic [SN_FWD_DATA_WIDTH-1:0]   rd_data,
  input  logic                           rd_data_vld,
  input  logic [PLEN_WIDTH-1:0]          byte_len,
  output logic                           done,
  input  logic                           rdy,
  output logic                           ack,
  output logic [SN_FWD_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [SN_FWD_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready
);
  localparam int AW    = SN_FWD_ADDR_WIDTH;
  localparam int DW    = SN_FWD_DATA_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int WW    = AW + 1;
  localparam int LW1   = PLEN_WIDTH + 1;
  localparam int PW    = $clog2(BUF_DEPTH);
  localparam int CW    = $clog2(BUF_DEPTH + 1);
  localparam int CW1   = CW + 1;
  localparam int EW    = DW + BYTES + 1;

  typedef enum logic [1:0] {IDLE, LATCH, READ, FINISH} state_t;
  state_t state_q, state_d;

  logic [WW-1:0]    words_q, words_d, issued_q, issued_d, recv_q, recv_d;
  logic [BYTES-1:0] last_keep_q, last_keep_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CW-1:0]    outst_q, outst_d, count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]    mem_q [BUF_DEPTH];

  logic [PLEN_WIDTH-1:0] len_quot, len_rem;
  logic [LW1-1:0]        words_raw;
  logic [WW-1:0]         words_sat;
  logic [BYTES-1:0]      keep_calc, push_keep;
  logic [CW1-1:0]        credit;
  logic [EW-1:0]         head;
  logic push, pop, fifo_empty, fifo_full, is_last_word;

  // Word count rounds up and saturates at the buffer size; the tail keep ignores saturation.
  assign len_quot  = byte_len / PLEN_WIDTH'(BYTES);
  assign len_rem   = byte_len % PLEN_WIDTH'(BYTES);
  assign words_raw = {1'b0, len_quot} + LW1'(len_rem != '0);
  assign words_sat = (words_raw > (LW1'(1) << AW)) ? (WW'(1) << AW) : words_raw[WW-1:0];
  assign keep_calc = (len_rem == '0) ? '1 : (BYTES'(1) << len_rem) - BYTES'(1);

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CW'(BUF_DEPTH));
  assign push         = rd_data_vld && (state_q == READ);
  assign pop          = !fifo_empty && m_axis_tready;
  assign is_last_word = (recv_q == words_q - WW'(1));
  assign push_keep    = is_last_word ? last_keep_q : '1;
  assign credit       = CW1'(outst_q) + CW1'(count_q);
  assign head         = mem_q[rd_ptr_q];

  assign addr          = addr_q;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = head[EW-1 -: DW];
  assign m_axis_tkeep  = head[BYTES:1];
  assign m_axis_tlast  = head[0] && !fifo_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rdy) state_d = LATCH;
      LATCH:   state_d = (words_sat == '0) ? FINISH : READ;
      READ:    if (pop && head[0]) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack   = 1'b0;
    rd_en = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE:    ack = rdy && rst_n;
      READ:    rd_en = (issued_q < words_q) && (credit < CW1'(BUF_DEPTH));
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    words_d     = words_q;
    last_keep_d = last_keep_q;
    addr_d      = addr_q;
    issued_d    = issued_q;
    recv_d      = recv_q;
    outst_d     = outst_q;
    if (state_q == LATCH) begin
      words_d     = words_sat;
      last_keep_d = keep_calc;
      addr_d      = '0;
      issued_d    = '0;
      recv_d      = '0;
      outst_d     = '0;
    end else begin
      // addr parks on the final word rather than stepping past it
      if (rd_en) begin
        issued_d = issued_q + WW'(1);
        if (issued_d < words_q) addr_d = addr_q + AW'(1);
      end
      if (push) recv_d = recv_q + WW'(1);
      outst_d = outst_q + CW'(rd_en) - CW'(push);
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_q     <= '0;
      last_keep_q <= '0;
      addr_q      <= '0;
      issued_q    <= '0;
      recv_q      <= '0;
      outst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      words_q     <= words_d;
      last_keep_q <= last_keep_d;
      addr_q      <= addr_d;
      issued_q    <= issued_d;
      recv_q      <= recv_d;
      outst_q     <= outst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {rd_data, push_keep, is_last_word};
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && fifo_full));
  end
endmodule

// File: tb/tb_axistream_forwarder.sv
// Bench for axistream_forwarder: buffer responder with configurable latency,
// stream monitor, table vectors, corner sequences and randomized packets.
`timescale 1ns/1ps
module tb_axistream_forwarder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic        rd_en;
  logic [63:0] rd_data;
  logic        rd_data_vld;
  logic [31:0] byte_len;
  logic        done, rdy, ack;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid, tready;

  always #5 clk = ~clk;

  axistream_forwarder #(
    .SN_FWD_ADDR_WIDTH(8),
    .SN_FWD_DATA_WIDTH(64),
    .PLEN_WIDTH(32),
    .BUF_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_data_vld(rd_data_vld), .byte_len(byte_len), .done(done), .rdy(rdy), .ack(ack),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready)
  );

  typedef struct { int due; logic [63:0] data; } resp_t;
  typedef struct { logic [63:0] data; logic [7:0] keep; logic last; int cyc; } beat_t;
  typedef struct { int len; int beats; logic [7:0] keep; } vec_t;

  resp_t rq[$];
  beat_t beats[$];
  int    raddrs[$];
  int    dones[$];
  int    cyc = 0, lat = 1, tag = 0, tr_mode = 0;
  logic  tr_man = 1'b1;
  int    vectors = 0, miscompares = 0;
  int    credit = 0, credit_max = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  function automatic logic [63:0] memword(input int t, input int a);
    logic [31:0] h;
    h = (32'(t) * 32'h9E3779B1) ^ (32'(a) * 32'h85EBCA6B);
    return {16'(t), 16'(a), h};
  endfunction

  function automatic int exp_words(input int len);
    int w;
    w = (len + 7) / 8;
    return (w > 256) ? 256 : w;
  endfunction

  function automatic logic [7:0] exp_keep(input int len);
    int r;
    r = len % 8;
    if (r == 0) return 8'hFF;
    return 8'((1 << r) - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Buffer responder, tready driver and stream monitor.
  initial begin
    resp_t r;
    beat_t b;
    rd_data = '0;
    rd_data_vld = 1'b0;
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        rd_data = rq[0].data;
        rd_data_vld = 1'b1;
        void'(rq.pop_front());
      end else begin
        rd_data = '0;
        rd_data_vld = 1'b0;
      end
      case (tr_mode)
        1:       tready = 1'($urandom_range(0, 1));
        2:       tready = tr_man;
        default: tready = 1'b1;
      endcase
      @(negedge clk);
      if (!rst_n) begin
        credit = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_tvalid", tvalid, 1);
          chk("stall_tdata", tdata, prev_beat.data);
          chk("stall_tkeep", tkeep, prev_beat.keep);
          chk("stall_tlast", tlast, prev_beat.last);
        end
        if (rd_en) begin
          r.due = cyc + lat;
          r.data = memword(tag, int'(addr));
          rq.push_back(r);
          raddrs.push_back(int'(addr));
          credit++;
        end
        b.data = tdata; b.keep = tkeep; b.last = tlast; b.cyc = cyc;
        if (tvalid && tready) begin
          beats.push_back(b);
          credit--;
        end
        if (credit > credit_max) credit_max = credit;
        if (done) dones.push_back(cyc);
        prev_stall = tvalid && !tready;
        prev_beat = b;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rdy = 1'b0;
    rq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start_pkt(input int len, input int t, output int ack_cyc);
    beats.delete();
    raddrs.delete();
    dones.delete();
    credit_max = 0;
    tag = t;
    @(posedge clk);
    #1;
    rdy = 1'b1;
    byte_len = 32'(len);
    @(negedge clk);
    chk("ack_with_rdy", ack, 1);
    ack_cyc = cyc;
    @(posedge clk);
    #1;
    rdy = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) begin
      chk("done_timeout", 0, 1);
      do_reset();
    end
    repeat (3) @(posedge clk);
  endtask

  // Reference: word i of a packet is memword(tag, i); tail keep/last from the length rules.
  task automatic check_pkt(input int len, input int t);
    int w, nbad, nlast;
    logic [7:0] k;
    w = exp_words(len);
    k = exp_keep(len);
    nbad = 0;
    nlast = 0;
    chk("beat_count", beats.size(), w);
    foreach (beats[i]) begin
      if (beats[i].last) nlast++;
      if (i < w) begin
        if (beats[i].data !== memword(t, i) ||
            beats[i].keep !== ((i == w - 1) ? k : 8'hFF) ||
            beats[i].last !== (i == w - 1)) nbad++;
      end
    end
    chk("stream_bad_beats", nbad, 0);
    chk("tlast_count", nlast, (w > 0) ? 1 : 0);
    chk("done_count", dones.size(), 1);
    chk("read_count", raddrs.size(), w);
    nbad = 0;
    foreach (raddrs[i]) if (raddrs[i] != i) nbad++;
    chk("read_addr_order", nbad, 0);
  endtask

  initial begin
    vec_t tbl[9];
    int ac, dc, len, lastc;
    tbl[0] = '{20,   3,   8'h0F};
    tbl[1] = '{16,   2,   8'hFF};
    tbl[2] = '{0,    0,   8'hFF};
    tbl[3] = '{1,    1,   8'h01};
    tbl[4] = '{9,    2,   8'h01};
    tbl[5] = '{63,   8,   8'h7F};
    tbl[6] = '{2047, 256, 8'h7F};
    tbl[7] = '{2049, 256, 8'h01};
    tbl[8] = '{4096, 256, 8'hFF};

    rst_n = 1'b0;
    rdy = 1'b0;
    byte_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", ack, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    lat = 1;
    tr_mode = 0;
    for (int v = 0; v < 9; v++) begin
      start_pkt(tbl[v].len, v + 1, ac);
      wait_done(dc);
      chk("vec_beats", beats.size(), tbl[v].beats);
      lastc = (beats.size() > 0) ? beats[beats.size() - 1].cyc : -100;
      if (beats.size() > 0) chk("vec_last_keep", beats[beats.size() - 1].keep, tbl[v].keep);
      if (tbl[v].beats == 0) chk("done_after_latch", dc, ac + 2);
      else                   chk("done_after_last_beat", dc, lastc + 1);
      check_pkt(tbl[v].len, v + 1);
    end

    // 64 bytes with tready dropped for 10 cycles right after the first beat.
    tr_mode = 2;
    tr_man = 1'b1;
    fork
      begin
        start_pkt(64, 200, ac);
        wait_done(dc);
      end
      begin
        for (int g = 0; g < 300 && beats.size() == 0; g++) @(posedge clk);
        tr_man = 1'b0;
        repeat (10) @(posedge clk);
        tr_man = 1'b1;
      end
    join
    chk("credit_within_depth", credit_max <= 4, 1);
    check_pkt(64, 200);
    tr_mode = 0;

    // Reset in the middle of a 5-beat packet, then a fresh packet.
    start_pkt(40, 300, ac);
    for (int g = 0; g < 300 && beats.size() < 2; g++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rq.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ack", ack, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("no_done_after_reset", dones.size(), 0);
    start_pkt(40, 301, ac);
    wait_done(dc);
    check_pkt(40, 301);

    // Randomized packets, read latency 3, random backpressure.
    lat = 3;
    tr_mode = 1;
    for (int p = 0; p < 100; p++) begin
      len = int'($urandom_range(1, 2048));
      start_pkt(len, 1000 + p, ac);
      wait_done(dc);
      check_pkt(len, 1000 + p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
